// File: rtl/xor_ring_pkg.sv
//------------------------------------------------------------------------------
// xor_ring_pkg
// Shared types and default sizing for the XOR ring oscillator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package xor_ring_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ACC_W  = 24;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } wr_state_t;

endpackage : xor_ring_pkg

`default_nettype wire

// File: rtl/xor_ring_chan.sv
//------------------------------------------------------------------------------
// xor_ring_chan
// One phase-accumulator channel: tune/enable registers, accumulator and
// the accumulator MSB for the next cycle. Hard-sync ports exist only when
// XOR_RING_SYNC_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xor_ring_chan
  import xor_ring_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr_stb,
  input  logic [ACC_W-1:0] wr_tune,
  input  logic             wr_en,
`ifdef XOR_RING_SYNC_EN
  input  logic             sync_in,
  output logic             carry_out,
`endif
  output logic             sq_next
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] tune_q, tune_d;
  logic             en_q, en_d;
  logic [ACC_W-1:0] sum;
  logic             load_zero;

`ifdef XOR_RING_SYNC_EN
  logic carry;

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, tune_q};
  assign carry_out    = tick && en_q && carry;
  // A sync pulse from the neighbour beats this channel's own increment.
  assign load_zero    = !en_q || sync_in;
`else
  assign sum       = acc_q + tune_q;
  assign load_zero = !en_q;
`endif

  // A tick always uses the registers as they were before this edge, so a
  // coinciding write only takes effect on the following tick.
  always_comb begin
    acc_d  = acc_q;
    tune_d = tune_q;
    en_d   = en_q;
    if (tick) begin
      acc_d = load_zero ? '0 : sum;
    end else if (wr_stb && !wr_en) begin
      acc_d = '0;
    end
    if (wr_stb) begin
      tune_d = wr_tune;
      en_d   = wr_en;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q  <= '0;
      tune_q <= '0;
      en_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tune_q <= tune_d;
      en_q   <= en_d;
    end
  end

  assign sq_next = acc_d[ACC_W-1];

endmodule : xor_ring_chan

`default_nettype wire

// File: rtl/xor_ring_osc.sv
//------------------------------------------------------------------------------
// xor_ring_osc
// Bank of NUM_CH phase-accumulator oscillators with a two-state write port
// and registered square / neighbour-XOR outputs.
// Optional macro: XOR_RING_SYNC_EN (channel i carry hard-syncs channel i+1).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xor_ring_osc
  import xor_ring_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]          cfg_tune,
  input  logic                      cfg_en,
  output logic [NUM_CH-1:0]         sq_out,
  output logic [NUM_CH-1:0]         ring_out
);

  localparam int CH_W = $clog2(NUM_CH);

  wr_state_t        state_q, state_d;
  logic             ready_q, ready_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [ACC_W-1:0] pend_tune_q, pend_tune_d;
  logic             pend_en_q, pend_en_d;
  logic             accept;

  logic [NUM_CH-1:0] wr_stb;
  logic [NUM_CH-1:0] sq_d, sq_q;
  logic [NUM_CH-1:0] ring_d, ring_q;

  always_comb begin
    accept      = cfg_valid && ready_q && (state_q == IDLE);
    state_d     = state_q;
    ready_d     = ready_q;
    pend_ch_d   = pend_ch_q;
    pend_tune_d = pend_tune_q;
    pend_en_d   = pend_en_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = COMMIT;
          ready_d     = 1'b0;
          pend_ch_d   = cfg_ch;
          pend_tune_d = cfg_tune;
          pend_en_d   = cfg_en;
        end else begin
          ready_d = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      pend_ch_q   <= '0;
      pend_tune_q <= '0;
      pend_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      pend_ch_q   <= pend_ch_d;
      pend_tune_q <= pend_tune_d;
      pend_en_q   <= pend_en_d;
    end
  end

  assign cfg_ready = ready_q;

`ifdef XOR_RING_SYNC_EN
  localparam logic [NUM_CH-1:0] SYNC_MASK = {{(NUM_CH-1){1'b1}}, 1'b0};

  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] sync;

  // Channel i is synced by channel i-1; the wrap from the last channel is masked.
  assign sync = {carry[NUM_CH-2:0], carry[NUM_CH-1]} & SYNC_MASK;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    // Out-of-range channel indices match no strobe, so the write is dropped.
    assign wr_stb[i] = (state_q == COMMIT) && (pend_ch_q == CH_W'(i));

    xor_ring_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick      (tick),
      .wr_stb    (wr_stb[i]),
      .wr_tune   (pend_tune_q),
      .wr_en     (pend_en_q),
`ifdef XOR_RING_SYNC_EN
      .sync_in   (sync[i]),
      .carry_out (carry[i]),
`endif
      .sq_next   (sq_d[i])
    );
  end

  always_comb begin
    ring_d = sq_d ^ {sq_d[0], sq_d[NUM_CH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sq_q   <= '0;
      ring_q <= '0;
    end else begin
      sq_q   <= sq_d;
      ring_q <= ring_d;
    end
  end

  assign sq_out   = sq_q;
  assign ring_out = ring_q;

endmodule : xor_ring_osc

`default_nettype wire

// File: tb/tb_xor_ring_osc.sv
//------------------------------------------------------------------------------
// tb_xor_ring_osc
// Self-checking bench: arithmetic reference model plus directed vectors.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xor_ring_osc;

  localparam int N = 2;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         tick;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [0:0]   cfg_ch;
  logic [W-1:0] cfg_tune;
  logic         cfg_en;
  logic [N-1:0] sq_out;
  logic [N-1:0] ring_out;

  // Three-channel instance for the out-of-range channel index case.
  logic         tick3;
  logic         v3;
  logic         rdy3;
  logic [1:0]   ch3;
  logic [W-1:0] tune3;
  logic         en3;
  logic [2:0]   sq3;
  logic [2:0]   ring3;

  always #5 clock = ~clock;

  xor_ring_osc #(.NUM_CH(N), .ACC_W(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .tick      (tick),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_tune  (cfg_tune),
    .cfg_en    (cfg_en),
    .sq_out    (sq_out),
    .ring_out  (ring_out)
  );

  xor_ring_osc #(.NUM_CH(3), .ACC_W(W)) dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .tick      (tick3),
    .cfg_valid (v3),
    .cfg_ready (rdy3),
    .cfg_ch    (ch3),
    .cfg_tune  (tune3),
    .cfg_en    (en3),
    .sq_out    (sq3),
    .ring_out  (ring3)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on integer accumulators.
  int unsigned m_acc[N];
  int unsigned m_tune[N];
  bit          m_en[N];
  int unsigned nxt[N];
  bit          wrap[N];
  int unsigned sum;
  bit          m_ready;
  bit          m_pend;
  int unsigned p_ch;
  int unsigned p_tune;
  bit          p_en;
  logic [N-1:0] exp_sq;
  logic [N-1:0] exp_ring;

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i]  = 0;
        m_tune[i] = 0;
        m_en[i]   = 1'b0;
      end
      m_ready = 1'b0;
      m_pend  = 1'b0;
    end else begin
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          sum     = m_acc[i] + m_tune[i];
          wrap[i] = m_en[i] && (sum >= (1 << W));
          nxt[i]  = m_en[i] ? (sum % (1 << W)) : 0;
        end
`ifdef XOR_RING_SYNC_EN
        for (int i = 1; i < N; i++) begin
          if (wrap[i-1]) nxt[i] = 0;
        end
`endif
        for (int i = 0; i < N; i++) m_acc[i] = nxt[i];
      end
      if (m_pend) begin
        m_pend  = 1'b0;
        m_ready = 1'b1;
        if (p_ch < N) begin
          m_tune[p_ch] = p_tune;
          m_en[p_ch]   = p_en;
          if (!p_en && !tick) m_acc[p_ch] = 0;
        end
      end else if (cfg_valid && m_ready) begin
        p_ch    = cfg_ch;
        p_tune  = cfg_tune;
        p_en    = cfg_en;
        m_pend  = 1'b1;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) exp_sq[i] = (m_acc[i] >= (1 << (W - 1)));
    for (int i = 0; i < N; i++) exp_ring[i] = exp_sq[i] ^ exp_sq[(i + 1) % N];
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check("model_ready", {31'd0, cfg_ready}, {31'd0, m_ready});
      check("model_sq", 32'(sq_out), 32'(exp_sq));
      check("model_ring", 32'(ring_out), 32'(exp_ring));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write(input int ch, input int tune, input bit en);
    cfg_valid = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_tune  = W'(tune);
    cfg_en    = en;
    cyc();
    cfg_valid = 1'b0;
    cyc();
  endtask

  bit         pat_solo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] pat_sq[4]   = '{2'b10, 2'b01, 2'b11, 2'b00};
  logic [1:0] pat_ring[4] = '{2'b11, 2'b11, 2'b00, 2'b00};
  bit         pat_s0[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
`ifdef XOR_RING_SYNC_EN
  bit         pat_s1[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
  bit         pat_s1[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
  logic [15:0] tick_pat   = 16'b1011_0010_1110_0101;

  initial begin
    reset_n = 1'b0; tick = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_tune = '0; cfg_en = 1'b0;
    tick3 = 1'b0; v3 = 1'b0; ch3 = '0; tune3 = '0; en3 = 1'b0;
    cyc();
    chk_on = 1'b1;
    cyc(2);
    check("rst_sq", 32'(sq_out), 32'h0);
    check("rst_ring", 32'(ring_out), 32'h0);
    check("rst_ready", {31'd0, cfg_ready}, 32'h0);
    reset_n = 1'b1;
    cyc();
    check("ready_after_rst", {31'd0, cfg_ready}, 32'h1);

    // Single channel, tune 0x40
    write(0, 'h40, 1'b1);
    tick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("solo_sq0", {31'd0, sq_out[0]}, {31'd0, pat_solo[k % 4]});
    end
    tick = 1'b0;
    cyc(2);

    // Reset while the write is in its commit cycle
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_tune = 8'h80; cfg_en = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc();
    tick = 1'b1;
    cyc(2);
    check("discard_sq", 32'(sq_out), 32'h0);
    tick = 1'b0;

    // Back-to-back writes with cfg_valid held
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_tune = 8'h40; cfg_en = 1'b1;
    cyc();
    check("b2b_ready_c2", {31'd0, cfg_ready}, 32'h0);
    cfg_ch = 1'b1; cfg_tune = 8'h80;
    cyc();
    check("b2b_ready_c3", {31'd0, cfg_ready}, 32'h1);
    cyc();
    check("b2b_ready_c4", {31'd0, cfg_ready}, 32'h0);
    cfg_valid = 1'b0;
    cyc();
    tick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("pair_sq", 32'(sq_out), 32'(pat_sq[k % 4]));
      check("pair_ring", 32'(ring_out), 32'(pat_ring[k % 4]));
    end

    // Disable ch0 while ticking: coinciding tick still uses old settings
    write(0, 'h40, 1'b0);
    check("coincide_old", {31'd0, sq_out[0]}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("disabled_sq0", {31'd0, sq_out[0]}, 32'h0);
    end
    tick = 1'b0;
    write(0, 'hC0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick = tick_pat[k];
      cyc();
    end
    tick = 1'b0;
    write(1, 'h10, 1'b0);
    check("idle_clear_sq1", {31'd0, sq_out[1]}, 32'h0);
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;

    // Hard-sync pattern (or independent channels without the macro)
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc();
    write(0, 'h80, 1'b1);
    write(1, 'h40, 1'b1);
    tick = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("sync_sq0", {31'd0, sq_out[0]}, {31'd0, pat_s0[k]});
      check("sync_sq1", {31'd0, sq_out[1]}, {31'd0, pat_s1[k]});
    end
    tick = 1'b0;

    // Three-channel instance: index 3 is accepted but writes nothing
    v3 = 1'b1; ch3 = 2'd2; tune3 = 8'h80; en3 = 1'b1;
    cyc();
    v3 = 1'b0;
    cyc();
    v3 = 1'b1; ch3 = 2'd3; tune3 = 8'h40; en3 = 1'b1;
    cyc();
    check("ch3_accept", {31'd0, rdy3}, 32'h0);
    v3 = 1'b0;
    cyc();
    check("ch3_done", {31'd0, rdy3}, 32'h1);
    tick3 = 1'b1;
    cyc();
    check("ch3_sq_t1", 32'(sq3), 32'h4);
    check("ch3_ring_t1", 32'(ring3), 32'h6);
    cyc();
    check("ch3_sq_t2", 32'(sq3), 32'h0);
    tick3 = 1'b0;
    cyc();

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_xor_ring_osc

`default_nettype wire
